rom_stream_reader: RTL and testbench

Sequential initiator for the team's synchronous-read, enable-gated ROM blocks. On a `start` command it issues `count` consecutive reads beginning at `startAddress`, wrapping at `memDepth`. It absorbs the ROM's one-cycle read latency and delivers the words in order on a valid/ready stream with backpressure. It sits between a ROM instance (e.g. a support-vector or coefficient table) and a downstream compute pipeline.

---
 rtl/rom_stream_reader.sv | 115 +++++++++++
 tb/tb_rom_stream_reader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rom_stream_reader.sv
// Streams `count` consecutive words out of a synchronous-read ROM onto a valid/ready
// interface, hiding the ROM's one-cycle read latency behind a 2-entry skid FIFO.
module rom_stream_reader #(
    parameter int blockLength = 12,
    parameter int memDepth = 250,
    localparam int addressBitWidth = (memDepth > 1) ? $clog2(memDepth) : 1
) (
    input  logic                       clock,
    input  logic                       resetN,
    input  logic                       start,
    input  logic [addressBitWidth-1:0] startAddress,
    input  logic [addressBitWidth:0]   count,
    output logic                       busy,
    output logic                       done,
    output logic [addressBitWidth-1:0] romAddress,
    output logic                       romEnable,
    input  logic [blockLength-1:0]     romData,
    output logic [blockLength-1:0]     outData,
    output logic                       outValid,
    input  logic                       outReady,
    output logic                       outLast
);

    localparam logic [addressBitWidth-1:0] lastAddress = addressBitWidth'(memDepth - 1);
    localparam logic [addressBitWidth:0]   oneWord     = (addressBitWidth + 1)'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                   state;
    logic [addressBitWidth:0] remaining;
    logic                     inflight;
    logic                     inflightLast;
    logic [blockLength-1:0]   fifoData [2];
    logic [1:0]               fifoLast;
    logic                     rdPtr;
    logic                     wrPtr;
    logic [1:0]               occupancy;
    logic                     pop;
    logic                     issue;

    assign outValid = (occupancy != 2'd0);
    assign outData  = fifoData[rdPtr];
    assign outLast  = outValid & fifoLast[rdPtr];
    assign pop      = outValid & outReady;

    // A read may only be issued if its word is guaranteed a FIFO slot when it returns.
    assign issue = (state == RUN) && (remaining != '0) &&
                   (({1'b0, occupancy} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
    assign romEnable = issue;

    // NOTE: all state here is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            romAddress   <= '0;
            remaining    <= '0;
            inflight     <= 1'b0;
            inflightLast <= 1'b0;
            // NOTE: the two FIFO slots are reset as well so outData reads 0 out of
            // reset instead of stale contents; a deep memory would not be reset.
            fifoData[0]  <= '0;
            fifoData[1]  <= '0;
            fifoLast     <= 2'b00;
            rdPtr        <= 1'b0;
            wrPtr        <= 1'b0;
            occupancy    <= 2'd0;
        end else begin
            done         <= 1'b0;
            inflight     <= issue;
            inflightLast <= issue && (remaining == oneWord);

            if (issue) begin
                romAddress <= (romAddress == lastAddress) ? '0 : romAddress + 1'b1;
                remaining  <= remaining - oneWord;
            end

            if (inflight) begin
                fifoData[wrPtr] <= romData;
                fifoLast[wrPtr] <= inflightLast;
                wrPtr           <= ~wrPtr;
            end
            if (pop) begin
                rdPtr <= ~rdPtr;
            end
            occupancy <= occupancy + {1'b0, inflight} - {1'b0, pop};

            case (state)
                IDLE: begin
                    if (start) begin
                        if (count == '0) begin
                            done <= 1'b1;
                        end else begin
                            romAddress <= startAddress;
                            remaining  <= count;
                            busy       <= 1'b1;
                            state      <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (pop && outLast) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: a table of commands run against a ROM model, with a
// scoreboard of expected addresses and words plus stall, occupancy and done checks.
module tb_rom_stream_reader;

    localparam int DEPTH = 250;
    localparam int W     = 12;

    logic         clock = 1'b0;
    logic         resetN = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   startAddress = '0;
    logic [8:0]   count = '0;
    logic         busy, done, romEnable, outValid, outLast;
    logic         outReady = 1'b0;
    logic [7:0]   romAddress;
    logic [W-1:0] romData = '0;
    logic [W-1:0] outData;

    rom_stream_reader #(.blockLength(W), .memDepth(DEPTH)) dut (
        .clock(clock), .resetN(resetN), .start(start), .startAddress(startAddress),
        .count(count), .busy(busy), .done(done), .romAddress(romAddress),
        .romEnable(romEnable), .romData(romData), .outData(outData),
        .outValid(outValid), .outReady(outReady), .outLast(outLast)
    );

    always #5 clock = ~clock;

    function automatic logic [W-1:0] rom_word(input int a);
        return W'((a * 73 + 19) ^ (a << 4));
    endfunction

    // Synchronous, enable-gated ROM: output is 0 on cycles without an enabled edge.
    logic [W-1:0] rom [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) rom[i] = rom_word(i);
    always @(posedge clock) romData <= romEnable ? rom[romAddress] : '0;

    typedef struct { logic [W-1:0] data; logic last; } word_t;
    typedef struct { int sa; int cnt; int mode; int inject; int lastAddr; } vec_t;

    word_t    sb [$];
    int       addr_q [$];
    int       checks = 0;
    int       passed = 0;
    int       issued = 0;
    int       popped = 0;
    int       enable_cnt = 0;
    int       last_addr = -1;
    bit       done_seen = 0;
    bit       exp_done = 0;
    bit       stall_prev = 0;
    bit       mon_en = 0;
    logic [W-1:0] stall_data = '0;
    int       pat [6] = '{0, 0, 1, 0, 1, 1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    function automatic logic rdy(input int mode, input int i);
        case (mode)
            0:       return 1'b1;
            1:       return pat[i % 6] != 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Monitor: outputs are sampled on the falling edge, inputs change just after rising.
    always @(negedge clock) begin
        if (resetN && mon_en) begin
            if (exp_done || done) check("done_pulse", done, exp_done);
            if (done) done_seen = 1;
            exp_done = (outValid && outReady && outLast) || (start && !busy && count == 0);
            if (stall_prev) begin
                check("stall_valid", outValid, 1);
                check("stall_hold", outData, stall_data);
            end
            stall_prev = outValid && !outReady;
            stall_data = outData;
            if (busy) check("outstanding_le2", (issued - popped) <= 2, 1);
            if (romEnable) begin
                check("issue_expected", addr_q.size() != 0, 1);
                if (addr_q.size() != 0) check("rom_address", romAddress, addr_q.pop_front());
                enable_cnt++;
                issued++;
                last_addr = romAddress;
            end
            if (outValid) begin
                check("word_expected", sb.size() != 0, 1);
                if (outReady && sb.size() != 0) begin
                    word_t w;
                    w = sb.pop_front();
                    check("out_data", outData, w.data);
                    check("out_last", outLast, w.last);
                    popped++;
                end
            end
        end
    end

    task automatic issue_start(input int sa, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            word_t w;
            w.data = rom_word((sa + k) % DEPTH);
            w.last = (k == cnt - 1);
            addr_q.push_back((sa + k) % DEPTH);
            sb.push_back(w);
        end
        start        = 1'b1;
        startAddress = 8'(sa);
        count        = 9'(cnt);
    endtask

    task automatic run_cmd(input vec_t v);
        enable_cnt = 0;
        done_seen  = 0;
        last_addr  = -1;
        @(posedge clock); #1;
        issue_start(v.sa, v.cnt);
        outReady = rdy(v.mode, 0);
        @(posedge clock); #1;
        for (int i = 1; i < 4000 && !done_seen; i++) begin
            if (i == v.inject) begin
                start = 1'b1; startAddress = 8'd0; count = 9'd2;
                check("busy_at_ignored_start", busy, 1);
            end else begin
                start = 1'b0;
            end
            outReady = rdy(v.mode, i);
            @(posedge clock); #1;
        end
        start = 1'b0;
        check("done_seen", done_seen, 1);
        check("enable_count", enable_cnt, v.cnt);
        if (v.cnt > 0) check("last_addr", last_addr, v.lastAddr);
        check("sb_empty", sb.size(), 0);
        check("busy_after", busy, 0);
    endtask

    vec_t vecs [8];

    initial begin
        vecs[0] = '{sa: 5,   cnt: 4,   mode: 0, inject: -1, lastAddr: 8};
        vecs[1] = '{sa: 248, cnt: 4,   mode: 0, inject: -1, lastAddr: 1};
        vecs[2] = '{sa: 100, cnt: 6,   mode: 1, inject: -1, lastAddr: 105};
        vecs[3] = '{sa: 0,   cnt: 1,   mode: 0, inject: -1, lastAddr: 0};
        vecs[4] = '{sa: 10,  cnt: 0,   mode: 0, inject: -1, lastAddr: 0};
        vecs[5] = '{sa: 50,  cnt: 6,   mode: 1, inject: 3,  lastAddr: 55};
        vecs[6] = '{sa: 200, cnt: 7,   mode: 2, inject: -1, lastAddr: 206};
        vecs[7] = '{sa: 249, cnt: 250, mode: 2, inject: -1, lastAddr: 248};

        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rom_enable", romEnable, 0);
        check("rst_rom_address", romAddress, 0);
        check("rst_out_valid", outValid, 0);
        check("rst_out_last", outLast, 0);
        check("rst_out_data", outData, 0);
        @(posedge clock); #1;
        resetN = 1'b1;
        mon_en = 1;

        for (int t = 0; t < 8; t++) run_cmd(vecs[t]);

        // Reset mid-transfer with two words parked in the FIFO.
        @(posedge clock); #1;
        outReady = 1'b0;
        issue_start(30, 6);
        @(posedge clock); #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("pre_reset_valid", outValid, 1);
        check("pre_reset_queued", issued - popped, 2);
        check("pre_reset_no_issue", romEnable, 0);
        @(posedge clock); #1;
        resetN = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_rom_enable", romEnable, 0);
        check("mid_rst_rom_address", romAddress, 0);
        check("mid_rst_out_valid", outValid, 0);
        check("mid_rst_out_last", outLast, 0);
        check("mid_rst_out_data", outData, 0);
        sb.delete();
        addr_q.delete();
        issued = 0; popped = 0;
        exp_done = 0; stall_prev = 0;
        repeat (2) @(posedge clock);
        #1;
        resetN = 1'b1;
        run_cmd('{sa: 0, cnt: 3, mode: 0, inject: -1, lastAddr: 2});

        repeat (3) @(posedge clock);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
